// File: rtl/blowfish128_cbc_ctrl.sv
// CBC-mode sequencer for the Blowfish-128 engine: chains 128-bit blocks through the
// engine one at a time and returns results over valid/ready.
module blowfish128_cbc_ctrl #(
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic         Encrypt,
    input  logic [127:0] iv,
    input  logic         Abort,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         eng_Enable,
    output logic         eng_Encrypt,
    output logic [127:0] eng_plainText,
    input  logic [127:0] eng_cipherText,
    input  logic         eng_cipherReady,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a source holds data stable while valid is high and ready is low.

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        RUN     = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t        state;
    logic [127:0]  chain;
    logic [127:0]  blk_in;
    logic          last_q;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            chain         <= '0;
            blk_in        <= '0;
            last_q        <= 1'b0;
            tmo_cnt       <= '0;
            out_data      <= '0;
            out_last      <= 1'b0;
            eng_Encrypt   <= 1'b0;
            eng_plainText <= '0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (Abort) begin
                state <= IDLE;
                chain <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            chain       <= iv;
                            eng_Encrypt <= Encrypt;
                            timeout_err <= 1'b0;
                            state       <= WAIT_IN;
                        end
                    end
                    WAIT_IN: begin
                        if (in_valid) begin
                            blk_in        <= in_data;
                            last_q        <= in_last;
                            eng_plainText <= eng_Encrypt ? (in_data ^ chain) : in_data;
                            tmo_cnt       <= '0;
                            state         <= RUN;
                        end
                    end
                    RUN: begin
                        // A response arriving on the timeout cycle is still honoured.
                        if (eng_cipherReady) begin
                            out_data <= eng_Encrypt ? eng_cipherText : (eng_cipherText ^ chain);
                            chain    <= eng_Encrypt ? eng_cipherText : blk_in;
                            out_last <= last_q;
                            state    <= OUT;
                        end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                            chain       <= '0;
                            state       <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    OUT: begin
                        if (out_ready) begin
                            done  <= last_q;
                            state <= last_q ? IDLE : WAIT_IN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready   = (state == WAIT_IN);
    assign eng_Enable = (state == RUN);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_blowfish128_cbc_ctrl.sv
// Directed bench for blowfish128_cbc_ctrl with a 5-cycle XOR-0xFF engine stub.
module tb_blowfish128_cbc_ctrl;

    logic         Clk = 1'b0;
    logic         Rst, Start, Encrypt, Abort, in_valid, in_last, out_ready;
    logic [127:0] iv, in_data;
    logic         in_ready, out_valid, out_last, eng_Enable, eng_Encrypt;
    logic [127:0] out_data, eng_plainText, eng_cipherText;
    logic         eng_cipherReady, busy, done, timeout_err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;

    // clock / reset
    always #5 Clk = ~Clk;

    blowfish128_cbc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Encrypt(Encrypt), .iv(iv), .Abort(Abort),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .eng_Enable(eng_Enable), .eng_Encrypt(eng_Encrypt), .eng_plainText(eng_plainText),
        .eng_cipherText(eng_cipherText), .eng_cipherReady(eng_cipherReady),
        .busy(busy), .done(done), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // engine stub: cipherText = plainText ^ 0xFF, ready 5 cycles after Enable rises
    logic [2:0]   stub_cnt;
    logic         stub_rdy, stub_on, force_rdy;
    logic [127:0] stub_ct;
    always @(posedge Clk) begin
        if (!eng_Enable) begin
            stub_cnt <= 3'd0;
            stub_rdy <= 1'b0;
        end else begin
            if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
            stub_rdy <= stub_on && (stub_cnt == 3'd4);
            stub_ct  <= eng_plainText ^ 128'hFF;
        end
    end
    assign eng_cipherReady = stub_rdy | force_rdy;
    assign eng_cipherText  = stub_ct;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks (inputs driven and outputs sampled on the falling edge)
    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic start_chain(input logic enc, input logic [127:0] v);
        Start = 1'b1; Encrypt = enc; iv = v;
        @(negedge Clk);
        Start = 1'b0; Encrypt = 1'b0; iv = '0;
        chk("start_busy", {127'd0, busy}, 128'd1);
        chk("start_in_ready", {127'd0, in_ready}, 128'd1);
    endtask

    task automatic push(input logic [127:0] d, input logic l, input logic [127:0] exp_pt,
                        input logic exp_enc);
        logic got = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin got = 1'b1; break; end
            @(negedge Clk);
        end
        chk("push_accept", {127'd0, got}, 128'd1);
        @(negedge Clk);
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        chk("run_enable", {127'd0, eng_Enable}, 128'd1);
        chk("run_plaintext", eng_plainText, exp_pt);
        chk("run_encrypt", {127'd0, eng_Encrypt}, {127'd0, exp_enc});
    endtask

    task automatic wait_out(input logic [127:0] exp_d, input logic exp_l, input int stall);
        logic got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin got = 1'b1; break; end
            @(negedge Clk);
        end
        chk("out_seen", {127'd0, got}, 128'd1);
        for (int i = 0; i < stall; i++) begin
            chk("bp_data", out_data, exp_d);
            chk("bp_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_enable", {127'd0, eng_Enable}, 128'd0);
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            @(negedge Clk);
        end
        chk("out_data", out_data, exp_d);
        chk("out_last", {127'd0, out_last}, {127'd0, exp_l});
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        if (exp_l) begin
            chk("done_pulse", {127'd0, done}, 128'd1);
            chk("end_idle", {127'd0, busy}, 128'd0);
            @(negedge Clk);
            chk("done_clear", {127'd0, done}, 128'd0);
        end else begin
            chk("next_in_ready", {127'd0, in_ready}, 128'd1);
        end
    endtask

    task automatic enc_chain(input int stall);
        start_chain(1'b1, 128'h1);
        push(128'h0, 1'b0, 128'h01, 1'b1);
        wait_out(128'hFE, 1'b0, stall);
        push(128'h10, 1'b1, 128'hEE, 1'b1);
        wait_out(128'h11, 1'b1, 0);
    endtask

    int en_cycles;
    logic saw_out;

    initial begin
        Rst = 1'b1; Start = 1'b0; Encrypt = 1'b0; iv = '0; Abort = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        stub_on = 1'b1; force_rdy = 1'b0;
        @(negedge Clk);
        do_reset();

        // reset state
        chk("rst_state", {126'd0, dbg_state}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_enable", {127'd0, eng_Enable}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_plaintext", eng_plainText, 128'd0);
        chk("rst_timeout_err", {127'd0, timeout_err}, 128'd0);

        // 1: encrypt chain
        enc_chain(0);

        // 2: decrypt chain
        start_chain(1'b0, 128'h1);
        push(128'hFE, 1'b0, 128'hFE, 1'b0);
        wait_out(128'h00, 1'b0, 0);
        push(128'h11, 1'b1, 128'h11, 1'b0);
        wait_out(128'h10, 1'b1, 0);

        // 3: back-pressure on the first encrypt output
        enc_chain(20);

        // 4: timeout with a silent engine
        stub_on = 1'b0;
        start_chain(1'b1, 128'h1);
        push(128'h0, 1'b1, 128'h01, 1'b1);
        en_cycles = 1;
        saw_out = 1'b0;
        for (int i = 0; i < 100 && eng_Enable; i++) begin
            @(negedge Clk);
            if (eng_Enable) en_cycles++;
            if (out_valid) saw_out = 1'b1;
        end
        repeat (3) begin
            @(negedge Clk);
            if (out_valid) saw_out = 1'b1;
        end
        chk("tmo_enable_cycles", 128'(en_cycles), 128'd16);
        chk("tmo_err", {127'd0, timeout_err}, 128'd1);
        chk("tmo_idle", {127'd0, busy}, 128'd0);
        chk("tmo_no_out", {127'd0, saw_out}, 128'd0);
        stub_on = 1'b1;
        start_chain(1'b1, 128'h1);
        chk("tmo_err_cleared", {127'd0, timeout_err}, 128'd0);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;

        // 5a: abort during RUN, then a late ready
        start_chain(1'b1, 128'h1);
        push(128'h0, 1'b0, 128'h01, 1'b1);
        @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_idle", {127'd0, busy}, 128'd0);
        chk("abort_enable", {127'd0, eng_Enable}, 128'd0);
        force_rdy = 1'b1;
        @(negedge Clk);
        force_rdy = 1'b0;
        @(negedge Clk);
        chk("abort_no_out", {127'd0, out_valid}, 128'd0);
        chk("abort_still_idle", {127'd0, busy}, 128'd0);
        enc_chain(0);

        // 5b: reset during RUN, then a late ready
        start_chain(1'b1, 128'h1);
        push(128'h0, 1'b0, 128'h01, 1'b1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rst_run_idle", {127'd0, busy}, 128'd0);
        chk("rst_run_enable", {127'd0, eng_Enable}, 128'd0);
        force_rdy = 1'b1;
        @(negedge Clk);
        force_rdy = 1'b0;
        @(negedge Clk);
        chk("rst_run_no_out", {127'd0, out_valid}, 128'd0);
        enc_chain(0);

        // 6: in_valid without Start, Start+Abort together, Start while busy
        in_valid = 1'b1; in_data = 128'h55;
        repeat (3) @(negedge Clk);
        chk("nostart_in_ready", {127'd0, in_ready}, 128'd0);
        chk("nostart_idle", {127'd0, busy}, 128'd0);
        in_valid = 1'b0; in_data = '0;
        Start = 1'b1; Abort = 1'b1; Encrypt = 1'b1; iv = 128'h1;
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0;
        chk("start_abort_idle", {127'd0, busy}, 128'd0);
        start_chain(1'b1, 128'h1);
        Start = 1'b1; Encrypt = 1'b0; iv = 128'hABCD;
        @(negedge Clk);
        Start = 1'b0; iv = '0;
        chk("busy_start_state", {126'd0, dbg_state}, 128'd1);
        push(128'h0, 1'b0, 128'h01, 1'b1);
        wait_out(128'hFE, 1'b0, 0);
        push(128'h10, 1'b1, 128'hEE, 1'b1);
        wait_out(128'h11, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

endmodule
